// File: rtl/adsr_poly.sv
// Polyphonic ADSR envelope generator. All voices share one adder and one
// comparator. A sample tick starts a sweep that services voice 0..NUM_VOICES-1
// on consecutive clocks and streams out each new level.
module adsr_poly #(
   parameter int NUM_VOICES  = 8,
   parameter int ACC_BITS    = 24,
   parameter int OUT_WIDTH   = 16,
   parameter int CTRL_WIDTH  = 4,
   parameter int SAMPLE_RATE = 48000,
   parameter int RETRIGGER   = 1,
   localparam int VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic [NUM_VOICES-1:0] gate,
   input  logic [CTRL_WIDTH-1:0] a,
   input  logic [CTRL_WIDTH-1:0] d,
   input  logic [CTRL_WIDTH-1:0] s,
   input  logic [CTRL_WIDTH-1:0] r,
   output logic                  out_valid,
   output logic [VW-1:0]         out_voice,
   output logic [OUT_WIDTH-1:0]  out_level,
   output logic [NUM_VOICES-1:0] active,
   output logic                  busy,
   output logic                  overrun
);

   localparam int NCODES = 2 ** CTRL_WIDTH;
   localparam logic [ACC_BITS-1:0] ACC_MAX    = '1;
   localparam logic [VW-1:0]       LAST_VOICE = VW'(NUM_VOICES - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_ATTACK, ST_DECAY, ST_SUSTAIN, ST_RELEASE
   } voice_state_e;

   // Attack time per code in microseconds; decay/release use three times this.
   function automatic longint t_us(input int code);
      case (code)
         0:  return 64'd2000;
         1:  return 64'd8000;
         2:  return 64'd16000;
         3:  return 64'd24000;
         4:  return 64'd38000;
         5:  return 64'd56000;
         6:  return 64'd68000;
         7:  return 64'd80000;
         8:  return 64'd100000;
         9:  return 64'd250000;
         10: return 64'd500000;
         11: return 64'd800000;
         12: return 64'd1000000;
         13: return 64'd3000000;
         14: return 64'd5000000;
         default: return 64'd8000000;
      endcase
   endfunction

   // Per-tick increment for every code: max(1, floor(2^ACC_BITS / (t * rate))).
   function automatic logic [NCODES*ACC_BITS-1:0] build_tbl(input int mult);
      logic [NCODES*ACC_BITS-1:0] tbl;
      longint den;
      longint q;
      tbl = '0;
      for (int c = 0; c < NCODES; c++) begin
         den = t_us(c) * longint'(mult) * longint'(SAMPLE_RATE);
         q   = ((64'sd1 <<< ACC_BITS) * 64'sd1000000) / den;
         if (q < 1) q = 1;
         tbl[c*ACC_BITS +: ACC_BITS] = ACC_BITS'(q);
      end
      return tbl;
   endfunction

   localparam logic [NCODES*ACC_BITS-1:0] INC_A_TBL  = build_tbl(1);
   localparam logic [NCODES*ACC_BITS-1:0] INC_DR_TBL = build_tbl(3);

   voice_state_e          state_q [NUM_VOICES];
   logic [ACC_BITS-1:0]   acc_q   [NUM_VOICES];
   logic [NUM_VOICES-1:0] prev_gate_q, gate_snap_q, active_q;
   logic [CTRL_WIDTH-1:0] a_q, d_q, s_q, r_q;
   logic                  busy_q, overrun_q, out_valid_q;
   logic [VW-1:0]         idx_q, out_voice_q;
   logic [OUT_WIDTH-1:0]  out_level_q;

   voice_state_e          cur_state, state_d;
   logic [ACC_BITS-1:0]   cur_acc, acc_d, inc_a, inc_d, inc_r, sl;
   logic [ACC_BITS:0]     sum_a, thr_d;
   logic                  g, rise;

   // Shared datapath: next state and level of the voice currently serviced.
   always_comb begin
      cur_state = state_q[idx_q];
      cur_acc   = acc_q[idx_q];
      g         = gate_snap_q[idx_q];
      rise      = g & ~prev_gate_q[idx_q];
      inc_a     = INC_A_TBL[int'(a_q)*ACC_BITS +: ACC_BITS];
      inc_d     = INC_DR_TBL[int'(d_q)*ACC_BITS +: ACC_BITS];
      inc_r     = INC_DR_TBL[int'(r_q)*ACC_BITS +: ACC_BITS];
      sl        = (&s_q) ? ACC_MAX : {s_q, {(ACC_BITS-CTRL_WIDTH){1'b0}}};
      // One extra bit keeps the add and the threshold free of wrap-around.
      sum_a     = {1'b0, cur_acc} + {1'b0, inc_a};
      thr_d     = {1'b0, sl} + {1'b0, inc_d};
      // NOTE: every comb output gets a default first, so no path can infer a latch.
      state_d   = cur_state;
      acc_d     = cur_acc;
      if ((RETRIGGER != 0) && rise) begin
         acc_d   = '0;
         state_d = ST_ATTACK;
      end else begin
         case (cur_state)
            ST_IDLE: if (g) state_d = ST_ATTACK;
            ST_ATTACK: begin
               if (!g) state_d = ST_RELEASE;
               else if (sum_a >= {1'b0, ACC_MAX}) begin
                  acc_d   = ACC_MAX;
                  state_d = ST_DECAY;
               end else acc_d = sum_a[ACC_BITS-1:0];
            end
            ST_DECAY: begin
               if (!g) state_d = ST_RELEASE;
               else if ({1'b0, cur_acc} <= thr_d) begin
                  acc_d   = sl;
                  state_d = ST_SUSTAIN;
               end else acc_d = cur_acc - inc_d;
            end
            ST_SUSTAIN: begin
               if (!g) state_d = ST_RELEASE;
               else acc_d = sl;
            end
            ST_RELEASE: begin
               if (g) state_d = ST_ATTACK;
               else if (cur_acc <= inc_r) begin
                  acc_d   = '0;
                  state_d = ST_IDLE;
               end else acc_d = cur_acc - inc_r;
            end
            default: begin
               acc_d   = '0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Sweep sequencer, per-voice state write-back and registered output stream.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the per-voice arrays are small flop banks, not RAM, so they are reset with everything else.
         for (int v = 0; v < NUM_VOICES; v++) begin
            state_q[v] <= ST_IDLE;
            acc_q[v]   <= '0;
         end
         prev_gate_q <= '0;
         gate_snap_q <= '0;
         active_q    <= '0;
         a_q         <= '0;
         d_q         <= '0;
         s_q         <= '0;
         r_q         <= '0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         out_valid_q <= 1'b0;
         idx_q       <= '0;
         out_voice_q <= '0;
         out_level_q <= '0;
      end else begin
         out_valid_q <= 1'b0;
         if (busy_q) begin
            state_q[idx_q]     <= state_d;
            acc_q[idx_q]       <= acc_d;
            prev_gate_q[idx_q] <= g;
            active_q[idx_q]    <= (state_d != ST_IDLE);
            out_valid_q        <= 1'b1;
            out_voice_q        <= idx_q;
            out_level_q        <= acc_d[ACC_BITS-1 -: OUT_WIDTH];
            if (idx_q == LAST_VOICE) begin
               busy_q <= 1'b0;
               idx_q  <= '0;
            end else begin
               idx_q  <= idx_q + VW'(1);
            end
            if (tick) overrun_q <= 1'b1;
         end else if (tick) begin
            busy_q      <= 1'b1;
            idx_q       <= '0;
            gate_snap_q <= gate;
            a_q         <= a;
            d_q         <= d;
            s_q         <= s;
            r_q         <= r;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_voice = out_voice_q;
   assign out_level = out_level_q;
   assign active    = active_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_adsr_poly.sv
// Bench for adsr_poly: two instances (hard retrigger and legato) share all
// stimulus; a behavioural envelope model fills one expectation queue per
// instance at each tick, and a negedge monitor pops and compares each level.
module tb_adsr_poly;

   localparam int S_IDLE = 0, S_ATK = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;
   localparam longint ACC_MAX_L = 64'hFFFFFF;

   typedef struct {
      int          voice;
      logic [15:0] level;
      logic        act;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic [7:0] gate = 8'h00;
   logic [3:0] a = 4'd0, d = 4'd0, s = 4'd8, r = 4'd15;

   logic        out_valid_rt, busy_rt, overrun_rt;
   logic [2:0]  out_voice_rt;
   logic [15:0] out_level_rt;
   logic [7:0]  active_rt;
   logic        out_valid_lg, busy_lg, overrun_lg;
   logic [2:0]  out_voice_lg;
   logic [15:0] out_level_lg;
   logic [7:0]  active_lg;

   int n_run = 0;
   int n_fail = 0;

   exp_t q_rt[$];
   exp_t q_lg[$];
   logic [15:0] last_rt [8];
   logic [15:0] last_lg [8];

   int     m_state [2][8];
   longint m_acc   [2][8];
   bit     m_prev  [2][8];

   real att_t [16] = '{0.002, 0.008, 0.016, 0.024, 0.038, 0.056, 0.068, 0.080,
                       0.1, 0.25, 0.5, 0.8, 1.0, 3.0, 5.0, 8.0};

   always #5 clk = ~clk;

   adsr_poly #(.NUM_VOICES(8), .RETRIGGER(1)) dut_rt (
      .clk(clk), .rst(rst), .tick(tick), .gate(gate),
      .a(a), .d(d), .s(s), .r(r),
      .out_valid(out_valid_rt), .out_voice(out_voice_rt), .out_level(out_level_rt),
      .active(active_rt), .busy(busy_rt), .overrun(overrun_rt)
   );

   adsr_poly #(.NUM_VOICES(8), .RETRIGGER(0)) dut_lg (
      .clk(clk), .rst(rst), .tick(tick), .gate(gate),
      .a(a), .d(d), .s(s), .r(r),
      .out_valid(out_valid_lg), .out_voice(out_voice_lg), .out_level(out_level_lg),
      .active(active_lg), .busy(busy_lg), .overrun(overrun_lg)
   );

   function automatic longint inc_of(input real t);
      real    x;
      longint q;
      x = 16777216.0 / (t * 48000.0);
      q = longint'($floor(x));
      if (q < 1) q = 1;
      return q;
   endfunction

   // Advance the envelope model by one tick for both instances, queue expectations.
   task automatic model_sweep();
      bit     gv, rise;
      longint acc, ia, id, ir, sl;
      int     st;
      exp_t   e;
      ia = inc_of(att_t[a]);
      id = inc_of(3.0 * att_t[d]);
      ir = inc_of(3.0 * att_t[r]);
      sl = (s == 4'hF) ? ACC_MAX_L : (longint'(s) << 20);
      for (int i = 0; i < 2; i++) begin
         for (int v = 0; v < 8; v++) begin
            gv   = gate[v];
            rise = gv && !m_prev[i][v];
            acc  = m_acc[i][v];
            st   = m_state[i][v];
            m_prev[i][v] = gv;
            if (rise && i == 0) begin
               acc = 0;
               st  = S_ATK;
            end else if (st == S_IDLE) begin
               if (gv) st = S_ATK;
            end else if (st == S_ATK) begin
               if (!gv) st = S_REL;
               else if (acc + ia >= ACC_MAX_L) begin acc = ACC_MAX_L; st = S_DEC; end
               else acc = acc + ia;
            end else if (st == S_DEC) begin
               if (!gv) st = S_REL;
               else if (acc <= sl + id) begin acc = sl; st = S_SUS; end
               else acc = acc - id;
            end else if (st == S_SUS) begin
               if (!gv) st = S_REL;
               else acc = sl;
            end else begin
               if (gv) st = S_ATK;
               else if (acc <= ir) begin acc = 0; st = S_IDLE; end
               else acc = acc - ir;
            end
            m_acc[i][v]   = acc;
            m_state[i][v] = st;
            e.voice = v;
            e.level = 16'(acc >> 8);
            e.act   = (st != S_IDLE);
            if (i == 0) q_rt.push_back(e);
            else q_lg.push_back(e);
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++)
         for (int v = 0; v < 8; v++) begin
            m_state[i][v] = S_IDLE;
            m_acc[i][v]   = 0;
            m_prev[i][v]  = 1'b0;
         end
   endtask

   // Scoreboard monitor: every level strobe must match the next queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid_rt) begin
         n_run++;
         if (q_rt.size() == 0) begin
            n_fail++;
            $display("FAIL sb_rt_unexpected: got voice %0d level %h, required no strobe", out_voice_rt, out_level_rt);
         end else begin
            e = q_rt.pop_front();
            last_rt[e.voice] = out_level_rt;
            if (out_voice_rt !== 3'(e.voice) || out_level_rt !== e.level || active_rt[e.voice] !== e.act) begin
               n_fail++;
               $display("FAIL sb_rt: got voice %0d level %h act %b, required voice %0d level %h act %b",
                        out_voice_rt, out_level_rt, active_rt[e.voice], e.voice, e.level, e.act);
            end
         end
      end
      if (out_valid_lg) begin
         n_run++;
         if (q_lg.size() == 0) begin
            n_fail++;
            $display("FAIL sb_lg_unexpected: got voice %0d level %h, required no strobe", out_voice_lg, out_level_lg);
         end else begin
            e = q_lg.pop_front();
            last_lg[e.voice] = out_level_lg;
            if (out_voice_lg !== 3'(e.voice) || out_level_lg !== e.level || active_lg[e.voice] !== e.act) begin
               n_fail++;
               $display("FAIL sb_lg: got voice %0d level %h act %b, required voice %0d level %h act %b",
                        out_voice_lg, out_level_lg, active_lg[e.voice], e.voice, e.level, e.act);
            end
         end
      end
   end

   // Issue one tick (sampled at the next edge) and let the whole sweep drain.
   task automatic run_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         tick = 1'b1;
         model_sweep();
         @(posedge clk); #1;
         tick = 1'b0;
         repeat (9) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      n_run++;
      if ({out_valid_rt, busy_rt, overrun_rt, out_voice_rt, out_level_rt, active_rt} !== '0) begin
         n_fail++;
         $display("FAIL reset_rt: got v%b b%b o%b voice %0d level %h act %h, required all zero",
                  out_valid_rt, busy_rt, overrun_rt, out_voice_rt, out_level_rt, active_rt);
      end
      n_run++;
      if ({out_valid_lg, busy_lg, overrun_lg, out_voice_lg, out_level_lg, active_lg} !== '0) begin
         n_fail++;
         $display("FAIL reset_lg: got v%b b%b o%b voice %0d level %h act %h, required all zero",
                  out_valid_lg, busy_lg, overrun_lg, out_voice_lg, out_level_lg, active_lg);
      end
   endtask

   task automatic test_attack_decay();
      a = 4'd0; d = 4'd0; s = 4'd8; r = 4'd15; gate = 8'h01;
      run_ticks(96);
      n_run++;
      if (last_rt[0] !== 16'hFD55) begin
         n_fail++; $display("FAIL attack_ramp: got %h, required fd55", last_rt[0]);
      end
      run_ticks(3);
      n_run++;
      if (last_rt[0] !== 16'hFF1C) begin
         n_fail++; $display("FAIL first_decay_step: got %h, required ff1c", last_rt[0]);
      end
      run_ticks(160);
      n_run++;
      if (last_rt[0] !== 16'h8000 || last_lg[0] !== 16'h8000) begin
         n_fail++; $display("FAIL sustain_level: got %h/%h, required 8000", last_rt[0], last_lg[0]);
      end
      n_run++;
      if (active_rt !== 8'h01 || active_lg !== 8'h01) begin
         n_fail++; $display("FAIL active_one_voice: got %h/%h, required 01", active_rt, active_lg);
      end
   endtask

   task automatic test_sustain_track();
      s = 4'd15;
      run_ticks(1);
      n_run++;
      if (last_rt[0] !== 16'hFFFF) begin
         n_fail++; $display("FAIL sustain_step_up: got %h, required ffff", last_rt[0]);
      end
      s = 4'd8;
      run_ticks(1);
      n_run++;
      if (last_rt[0] !== 16'h8000) begin
         n_fail++; $display("FAIL sustain_step_down: got %h, required 8000", last_rt[0]);
      end
   endtask

   task automatic test_release();
      gate = 8'h00;
      run_ticks(3);
      n_run++;
      if (last_rt[0] !== 16'h7FFF) begin
         n_fail++; $display("FAIL slow_release: got %h, required 7fff", last_rt[0]);
      end
      r = 4'd0;
      run_ticks(150);
      n_run++;
      if (active_rt !== 8'h00 || active_lg !== 8'h00 || last_rt[0] !== 16'h0000) begin
         n_fail++; $display("FAIL release_to_idle: got act %h/%h level %h, required 00/00 0000",
                            active_rt, active_lg, last_rt[0]);
      end
   endtask

   task automatic test_retrigger();
      a = 4'd0; gate = 8'h01;
      run_ticks(25);
      gate = 8'h00;
      run_ticks(1);
      n_run++;
      if (last_rt[0] !== 16'h3FFF || last_lg[0] !== 16'h3FFF) begin
         n_fail++; $display("FAIL release_hold: got %h/%h, required 3fff", last_rt[0], last_lg[0]);
      end
      gate = 8'h01;
      run_ticks(1);
      n_run++;
      if (last_rt[0] !== 16'h0000 || last_lg[0] !== 16'h3FFF) begin
         n_fail++; $display("FAIL reraise: got %h/%h, required 0000/3fff", last_rt[0], last_lg[0]);
      end
      run_ticks(1);
      n_run++;
      if (last_rt[0] !== 16'h02AA || last_lg[0] !== 16'h42AA) begin
         n_fail++; $display("FAIL after_reraise: got %h/%h, required 02aa/42aa", last_rt[0], last_lg[0]);
      end
   endtask

   task automatic test_snapshot();
      gate = 8'hA5; a = 4'd2; d = 4'd1; s = 4'd4;
      run_ticks(1);
      @(posedge clk); #1;
      tick = 1'b1;
      model_sweep();
      @(posedge clk); #1;
      tick = 1'b0;
      @(posedge clk); #1;
      a = 4'd15; d = 4'd15;
      repeat (9) @(posedge clk);
      #1;
      n_run++;
      if (last_rt[5] !== 16'h0055 || last_lg[5] !== 16'h0055) begin
         n_fail++; $display("FAIL snapshot_a: got %h/%h, required 0055", last_rt[5], last_lg[5]);
      end
      run_ticks(1);
   endtask

   task automatic test_back_to_back();
      gate = 8'hFF; a = 4'd0;
      n_run++;
      if (overrun_rt !== 1'b0) begin
         n_fail++; $display("FAIL overrun_clear: got %b, required 0", overrun_rt);
      end
      @(posedge clk); #1;
      tick = 1'b1;
      model_sweep();
      @(posedge clk); #1;
      tick = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_run++;
         if (busy_rt !== (k <= 7) || out_valid_rt !== (k >= 1 && k <= 8)) begin
            n_fail++; $display("FAIL sweep_timing k=%0d: got busy %b valid %b, required busy %b valid %b",
                               k, busy_rt, out_valid_rt, (k <= 7), (k >= 1 && k <= 8));
         end
         if (k == 4) tick = 1'b1;
         if (k == 5) tick = 1'b0;
      end
      n_run++;
      if (overrun_rt !== 1'b1 || overrun_lg !== 1'b1) begin
         n_fail++; $display("FAIL overrun_set: got %b/%b, required 1", overrun_rt, overrun_lg);
      end
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_midsweep();
      gate = 8'hA5;
      @(posedge clk); #1;
      tick = 1'b1;
      model_sweep();
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      q_rt.delete();
      q_lg.delete();
      model_reset();
      repeat (12) @(negedge clk);
      n_run++;
      if (active_rt !== 8'h00 || overrun_rt !== 1'b0 || busy_rt !== 1'b0 || out_valid_rt !== 1'b0) begin
         n_fail++; $display("FAIL midsweep_reset: got act %h ovr %b busy %b valid %b, required 00 0 0 0",
                            active_rt, overrun_rt, busy_rt, out_valid_rt);
      end
      run_ticks(2);
      n_run++;
      if (last_rt[0] !== 16'h02AA || last_lg[0] !== 16'h02AA || active_rt !== 8'hA5) begin
         n_fail++; $display("FAIL restart_after_reset: got %h/%h act %h, required 02aa/02aa a5",
                            last_rt[0], last_lg[0], active_rt);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int v = 0; v < 8; v++) begin
         last_rt[v] = '0;
         last_lg[v] = '0;
      end
      model_reset();
      test_reset();
      test_attack_decay();
      test_sustain_track();
      test_release();
      test_retrigger();
      test_snapshot();
      test_back_to_back();
      test_reset_midsweep();
      n_run++;
      if (q_rt.size() != 0 || q_lg.size() != 0) begin
         n_fail++; $display("FAIL sb_drain: got %0d/%0d pending, required 0", q_rt.size(), q_lg.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
